// File: rtl/load_sequencer.sv
// Multi-cycle load sequencer: issues one memory read, waits MEM_LATENCY cycles, then extracts and extends a byte/halfword/word.
// Optional feature macro: LOAD_SEQUENCER_SIGN_EXT_EN (honours load_signed when defined).
module load_sequencer #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  load_size,
  input  logic        load_signed,
  input  logic [31:0] address,
  input  logic [31:0] mem_data_in,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data_out,
  output logic        misaligned
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_lane;
  logic [1:0]         r_size;
  logic               r_signed;
  logic [31:0]        r_mem_addr;
  logic               r_mem_read;
  logic               r_busy;
  logic               r_done;
  logic [31:0]        r_data;
  logic               r_misaligned;

  logic               w_misaligned;
  logic               w_sext;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_ext;

  // Reserved size 2'b11 is treated as a word, including its alignment rule
  always_comb begin
    w_misaligned = 1'b0;
    case (load_size)
      2'b01:   w_misaligned = address[0];
      2'b10:   w_misaligned = 1'b0;
      default: w_misaligned = (address[1:0] != 2'b00);
    endcase
  end

`ifdef LOAD_SEQUENCER_SIGN_EXT_EN
  assign w_sext = r_signed;
`else
  logic w_unused_signed;
  assign w_unused_signed = r_signed;
  assign w_sext          = 1'b0;
`endif

  // Little-endian lane select plus extension of the captured lane
  always_comb begin
    w_byte = mem_data_in[7:0];
    case (r_lane)
      2'd0:    w_byte = mem_data_in[7:0];
      2'd1:    w_byte = mem_data_in[15:8];
      2'd2:    w_byte = mem_data_in[23:16];
      default: w_byte = mem_data_in[31:24];
    endcase
    w_half = r_lane[1] ? mem_data_in[31:16] : mem_data_in[15:0];
    case (r_size)
      2'b10:   w_ext = {{24{w_sext & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{w_sext & w_half[15]}}, w_half};
      default: w_ext = mem_data_in;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_lane       <= '0;
      r_size       <= '0;
      r_signed     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_read   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_data       <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_mem_addr   <= '0;
      r_mem_read   <= 1'b0;
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_misaligned) begin
              r_misaligned <= 1'b1;
            end else begin
              r_lane     <= address[1:0];
              r_size     <= load_size;
              r_signed   <= load_signed;
              r_mem_addr <= {address[31:2], 2'b00};
              r_mem_read <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= S_READ;
            end
          end
        end
        S_READ: begin
          r_cnt   <= CNT_W'(MEM_LATENCY);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Leaving on the decrement to zero keeps WAIT exactly MEM_LATENCY cycles
          if (r_cnt <= CNT_W'(1)) begin
            r_cnt   <= '0;
            r_state <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_CAPTURE: begin
          r_data  <= w_ext;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr      = r_mem_addr;
  assign mem_read      = r_mem_read;
  assign busy          = r_busy;
  assign done          = r_done;
  assign load_data_out = r_data;
  assign misaligned    = r_misaligned;

endmodule
